carry_select_adder: RTL and testbench

CARRY_SELECT_ADDER -- requirements
Module: carry_select_adder

---
 rtl/carry_select_adder.sv | 70 +++++++
 tb/tb_carry_select_adder.sv | 89 ++++++++
 2 files changed

// File: rtl/carry_select_adder.sv
// carry_select_adder: parameterised carry-select adder with a registered result copy
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ c;
  assign cout = (x & y) | (x & c) | (y & c);
endmodule

module carry_select_adder #(
  parameter int N   = 4,
  parameter int BLK = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co,
  output logic [N-1:0] sum_q,
  output logic         co_q
);
  localparam int NB = (N + BLK - 1) / BLK;
  logic [NB:0]  bc;
  logic [N-1:0] sum_d;
  logic         co_d;
  assign bc[0] = ci;
  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int W  = (LO + BLK > N) ? N - LO : BLK;
    if (k == 0) begin : g_rc
      logic [W:0] c;
      assign c[0] = bc[0];
      for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (.x(a[LO+i]), .y(b[LO+i]), .c(c[i]), .s(sum[LO+i]), .cout(c[i+1]));
      end
      assign bc[1] = c[W];
    end else begin : g_cs
      // Both carry-in hypotheses ripple in parallel; the real carry only steers the muxes
      logic [W:0]   c0, c1;
      logic [W-1:0] s0, s1;
      assign c0[0] = 1'b0;
      assign c1[0] = 1'b1;
      for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa0 (.x(a[LO+i]), .y(b[LO+i]), .c(c0[i]), .s(s0[i]), .cout(c0[i+1]));
        full_adder u_fa1 (.x(a[LO+i]), .y(b[LO+i]), .c(c1[i]), .s(s1[i]), .cout(c1[i+1]));
      end
      assign sum[LO+W-1:LO] = bc[k] ? s1 : s0;
      assign bc[k+1]        = bc[k] ? c1[W] : c0[W];
    end
  end
  assign co = bc[NB];
  always_comb begin
    sum_d = sum;
    co_d  = co;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end
endmodule

// File: tb/tb_carry_select_adder.sv
// tb_carry_select_adder: random and directed checks of the carry-select adder against plain arithmetic
module tb_carry_select_adder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] a = '0, b = '0, sum, sum_q;
  logic       ci = 1'b0, co, co_q;
  logic [7:0] a8 = '0, b8 = '0, s1, s3, s8, s1q, s3q, s8q;
  logic       ci8 = 1'b0, c1, c3, c8, c1q, c3q, c8q;
  int         checks = 0, fails = 0, loops = 0;
  logic [4:0] sbq[$];

  carry_select_adder #(.N(4), .BLK(2)) dut (.clk(clk), .reset(reset), .a(a), .b(b), .ci(ci),
    .sum(sum), .co(co), .sum_q(sum_q), .co_q(co_q));
  carry_select_adder #(.N(8), .BLK(1)) dut_b1 (.clk(clk), .reset(reset), .a(a8), .b(b8), .ci(ci8),
    .sum(s1), .co(c1), .sum_q(s1q), .co_q(c1q));
  carry_select_adder #(.N(8), .BLK(3)) dut_b3 (.clk(clk), .reset(reset), .a(a8), .b(b8), .ci(ci8),
    .sum(s3), .co(c3), .sum_q(s3q), .co_q(c3q));
  carry_select_adder #(.N(8), .BLK(8)) dut_b8 (.clk(clk), .reset(reset), .a(a8), .b(b8), .ci(ci8),
    .sum(s8), .co(c8), .sum_q(s8q), .co_q(c8q));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic comb4(input string name, input int ai, input int bi, input int cii);
    a = 4'(ai); b = 4'(bi); ci = 1'(cii);
    #5 chk(name, {27'd0, co, sum}, 32'(ai + bi + cii));
  endtask

  task automatic comb8(input int ai, input int bi, input int cii);
    a8 = 8'(ai); b8 = 8'(bi); ci8 = 1'(cii);
    #5;
    chk("n8_blk1", {23'd0, c1, s1}, 32'(ai + bi + cii));
    chk("n8_blk3", {23'd0, c3, s3}, 32'(ai + bi + cii));
    chk("n8_blk8", {23'd0, c8, s8}, 32'(ai + bi + cii));
  endtask

  // Registered-path expectations are queued at drive time and retired one edge later
  task automatic drive_reg(input logic r, input int ai, input int bi, input int cii);
    @(negedge clk);
    reset = r; a = 4'(ai); b = 4'(bi); ci = 1'(cii);
    sbq.push_back(r ? 5'd0 : 5'(ai + bi + cii));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) chk("registered", {27'd0, co_q, sum_q}, {27'd0, sbq.pop_front()});
    end
  end

  initial begin
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int cii = 0; cii < 2; cii++) begin
          comb4("exhaustive", ai, bi, cii);
          loops++;
        end
    chk("exhaustive_count", 32'(loops), 32'd512);
    comb4("corner_zero", 0, 0, 0);
    comb4("corner_max", 15, 15, 1);
    comb4("corner_wrap", 15, 0, 1);
    comb4("blk_carry", 3, 1, 0);
    comb4("blk_chain", 5, 10, 1);
    for (int i = 0; i < 100; i++) comb8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    comb8(255, 1, 0);
    comb8(255, 255, 1);
    drive_reg(1'b1, 5, 6, 1);
    drive_reg(1'b0, 9, 8, 0);
    for (int i = 0; i < 60; i++)
      drive_reg($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    drive_reg(1'b0, 7, 7, 0);
    drive_reg(1'b1, 7, 7, 0);
    #1 chk("reset_comb", {27'd0, co, sum}, 32'd14);
    drive_reg(1'b0, 12, 9, 1);
    drive_reg(1'b0, 1, 2, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
